// File: rtl/ram_2w1r.sv
// ram_2w1r: 64x8 dual-write single-read RAM with post-reset zeroing sequencer
//   clk, rst            clock, synchronous active-high reset
//   en                  block enable (no write, no read, init paused when 0)
//   wr_en_a/addr_a/data_a  port A write (wins on address collision)
//   wr_en_b/addr_b/data_b  port B write
//   rd_addr, rd_data    read address, registered read-first data
//   init_busy           high while the array is being zeroed
//   wr_collide          one-cycle pulse when A and B hit the same address
//   collide_cnt         saturating collision count since reset
module ram_2w1r #(
  parameter int DW    = 8,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          wr_en_a,
  input  logic [AW-1:0] wr_addr_a,
  input  logic [DW-1:0] wr_data_a,
  input  logic          wr_en_b,
  input  logic [AW-1:0] wr_addr_b,
  input  logic [DW-1:0] wr_data_b,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          init_busy,
  output logic          wr_collide,
  output logic [7:0]    collide_cnt
);
  typedef enum logic {INIT, READY} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] init_ptr_q, init_ptr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          wr_collide_q, wr_collide_d;
  logic [7:0]    collide_cnt_q, collide_cnt_d;
  logic [DW-1:0] ram [DEPTH];
  logic          init_step, ready_en;
  always_comb begin
    init_step     = state_q == INIT && en;
    ready_en      = state_q == READY && en;
    init_ptr_d    = init_step ? init_ptr_q + 1'b1 : init_ptr_q;
    state_d       = init_step && init_ptr_q == AW'(DEPTH - 1) ? READY : state_q;
    wr_collide_d  = ready_en && wr_en_a && wr_en_b && wr_addr_a == wr_addr_b;
    collide_cnt_d = wr_collide_d && collide_cnt_q != 8'hff ? collide_cnt_q + 8'd1 : collide_cnt_q;
    // array read happens before this edge's writes land, giving read-first behaviour
    rd_data_d     = ready_en ? ram[rd_addr] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT;
      init_ptr_q    <= '0;
      rd_data_q     <= '0;
      wr_collide_q  <= 1'b0;
      collide_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      init_ptr_q    <= init_ptr_d;
      rd_data_q     <= rd_data_d;
      wr_collide_q  <= wr_collide_d;
      collide_cnt_q <= collide_cnt_d;
    end
  end
  // B is written before A so a same-address A write overrides it
  always_ff @(posedge clk) begin
    if (!rst && init_step) ram[init_ptr_q] <= '0;
    if (!rst && ready_en && wr_en_b) ram[wr_addr_b] <= wr_data_b;
    if (!rst && ready_en && wr_en_a) ram[wr_addr_a] <= wr_data_a;
  end
  assign rd_data     = rd_data_q;
  assign init_busy   = state_q == INIT;
  assign wr_collide  = wr_collide_q;
  assign collide_cnt = collide_cnt_q;
endmodule
